// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives a synchronous-read IMEM and
// registers IF/ID, with a one-entry skid buffer so decode stalls lose nothing.
module fetch_stage #(
    parameter int                XLEN      = 32,
    parameter int                IMEM_AW   = 9,
    parameter logic [XLEN-1:0]   RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0]   NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [XLEN-1:0]      redirect_pc,
    output logic [IMEM_AW-1:0]   imem_addr,
    input  logic [XLEN-1:0]      imem_rdata,
    output logic                 if_id_valid,
    output logic [XLEN-1:0]      if_id_instr,
    output logic [XLEN-1:0]      if_id_pc,
    output logic [XLEN-1:0]      if_id_pc4
);

    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

    logic [XLEN-1:0] pc_f_q, pc_f_d;
    logic            req_valid_q, req_valid_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic            if_id_valid_q, if_id_valid_d;
    logic [XLEN-1:0] if_id_instr_q, if_id_instr_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
    logic [XLEN-1:0] if_id_pc4_q, if_id_pc4_d;
    logic            unused_redirect_lsb_s;

    assign imem_addr             = pc_f_q[IMEM_AW+1:2];
    assign if_id_valid           = if_id_valid_q;
    assign if_id_instr           = if_id_instr_q;
    assign if_id_pc              = if_id_pc_q;
    assign if_id_pc4             = if_id_pc4_q;
    assign unused_redirect_lsb_s = ^redirect_pc[1:0];

    // Next-state: flush beats stall; a read is issued only in an unstalled, unflushed cycle.
    always_comb begin
        pc_f_d        = pc_f_q;
        req_valid_d   = 1'b0;
        req_pc_d      = req_pc_q;
        skid_valid_d  = skid_valid_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        if_id_valid_d = if_id_valid_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_pc4_d   = if_id_pc4_q;
        if (flush) begin
            pc_f_d        = {redirect_pc[XLEN-1:2], 2'b00};
            skid_valid_d  = 1'b0;
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
        end else if (stall) begin
            // The in-flight read's data is only on imem_rdata this cycle, so park it.
            if (req_valid_q && !skid_valid_q) begin
                skid_valid_d = 1'b1;
                skid_instr_d = imem_rdata;
                skid_pc_d    = req_pc_q;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end else begin
            req_valid_d = 1'b1;
            req_pc_d    = pc_f_q;
            pc_f_d      = pc_f_q + PC_STEP;
            if (skid_valid_q) begin
                skid_valid_d  = 1'b0;
                if_id_valid_d = 1'b1;
                if_id_instr_d = skid_instr_q;
                if_id_pc_d    = skid_pc_q;
                if_id_pc4_d   = skid_pc_q + PC_STEP;
            end else if (req_valid_q) begin
                if_id_valid_d = 1'b1;
                if_id_instr_d = imem_rdata;
                if_id_pc_d    = req_pc_q;
                if_id_pc4_d   = req_pc_q + PC_STEP;
            end else begin
                if_id_valid_d = 1'b0;
                if_id_instr_d = NOP_INSTR;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f_q        <= RESET_PC;
            req_valid_q   <= 1'b0;
            req_pc_q      <= {XLEN{1'b0}};
            skid_valid_q  <= 1'b0;
            skid_instr_q  <= NOP_INSTR;
            skid_pc_q     <= {XLEN{1'b0}};
            if_id_valid_q <= 1'b0;
            if_id_instr_q <= NOP_INSTR;
            if_id_pc_q    <= {XLEN{1'b0}};
            if_id_pc4_q   <= {XLEN{1'b0}};
        end else begin
            pc_f_q        <= pc_f_d;
            req_valid_q   <= req_valid_d;
            req_pc_q      <= req_pc_d;
            skid_valid_q  <= skid_valid_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_pc4_q   <= if_id_pc4_d;
        end
    end

    fetch_stage_chk u_chk (
        .clk          (clk),
        .reset        (reset),
        .req_valid_i  (req_valid_q),
        .skid_valid_i (skid_valid_q)
    );

endmodule

// Invariant checker: a pending read and a full skid can never coexist.
module fetch_stage_chk (
    input  logic clk,
    input  logic reset,
    input  logic req_valid_i,
    input  logic skid_valid_i
);

    a_no_req_with_skid: assert property (@(posedge clk) disable iff (reset)
        !(req_valid_i && skid_valid_i));

endmodule
